// File: rtl/riscv_mem_defs.sv
// Shared encodings and default sizing for the unified memory arbiter.
package riscv_mem_defs;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_MAX_STREAK = 4;
endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; done when it reaches zero.
module mem_lat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= loadVal;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and the data stage,
// data-first with a bounded streak so fetch cannot starve.
module unified_mem_arbiter
  import riscv_mem_defs::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int unsigned CNT_W  = $clog2(MEM_LAT + 1);
  localparam int unsigned STRK_W = $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_STREAK);

  arb_state_e        state, nextState;
  owner_e            owner;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [STRK_W-1:0] streak;
  logic [DATA_W-1:0] ifRdataQ, dmRdataQ;
  logic              grantDm, grantIf, grantAny;
  logic              latLoad, latDec, latDone;

  always_comb begin
    grantDm   = dm_req & (~if_req | (streak < STRK_MAX));
    grantIf   = ~grantDm & if_req;
    grantAny  = grantDm | grantIf;
    nextState = state;
    latLoad   = 1'b0;
    latDec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grantAny) begin
          nextState = ACCESS;
          latLoad   = 1'b1;
        end
      end
      ACCESS: begin
        if (latDone) nextState = RESP;
        else         latDec    = 1'b1;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= OWN_IF;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      streak   <= '0;
    end else if (state == IDLE && grantAny) begin
      owner    <= grantDm ? OWN_DM : OWN_IF;
      latWe    <= grantDm & dm_we;
      latAddr  <= grantDm ? dm_addr : if_addr;
      latWdata <= grantDm ? dm_wdata : '0;
      if (grantDm && if_req) begin
        if (streak != STRK_MAX) streak <= streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifRdataQ <= '0;
      dmRdataQ <= '0;
    end else if (state == ACCESS && latDone) begin
      if (owner == OWN_IF)  ifRdataQ <= mem_rdata;
      else if (!latWe)      dmRdataQ <= mem_rdata;
    end
  end

  mem_lat_counter #(.CNT_W(CNT_W)) uLatCnt (
    .clk     (clk),
    .rst_n   (rst),
    .load    (latLoad),
    .dec     (latDec),
    .loadVal (LAT_LOAD),
    .done    (latDone)
  );

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & latWe;
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;
  assign if_ack    = (state == RESP) & (owner == OWN_IF);
  assign dm_ack    = (state == RESP) & (owner == OWN_DM);
  assign if_rdata  = ifRdataQ;
  assign dm_rdata  = dmRdataQ;
  // Gated by reset so the hazard unit sees no stall while the arbiter is held.
  assign stall_if  = rst & if_req & ~if_ack;
  assign stall_mem = rst & dm_req & ~dm_ack;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: default build plus a MEM_LAT=1 build.
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, dmReq, dmWe;
  logic [31:0] ifAddr, dmAddr, dmWdata;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
  logic        ifAck, dmAck, memEn, memWe, stallIf, stallMem;

  logic        if2Req, dm2Req, dm2We;
  logic [31:0] if2Addr, dm2Addr, dm2Wdata;
  logic [31:0] if2Rdata, dm2Rdata, mem2Addr, mem2Wdata, mem2Rdata;
  logic        if2Ack, dm2Ack, mem2En, mem2We, stall2If, stall2Mem;

  logic [31:0] mem [0:255];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .dm_ack(dmAck),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .stall_if(stallIf), .stall_mem(stallMem)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if2Req), .if_addr(if2Addr), .if_rdata(if2Rdata), .if_ack(if2Ack),
    .dm_req(dm2Req), .dm_we(dm2We), .dm_addr(dm2Addr), .dm_wdata(dm2Wdata),
    .dm_rdata(dm2Rdata), .dm_ack(dm2Ack),
    .mem_en(mem2En), .mem_we(mem2We), .mem_addr(mem2Addr), .mem_wdata(mem2Wdata),
    .mem_rdata(mem2Rdata), .stall_if(stall2If), .stall_mem(stall2Mem)
  );

  assign memRdata  = mem[memAddr[9:2]];
  assign mem2Rdata = mem2Addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (!rst) mem[4] <= 32'h0050_0093;
    else if (memEn && memWe) mem[memAddr[9:2]] <= memWdata;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1);
  end

  task automatic doAcc(input bit isDm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int ackCyc, output int enCyc,
                       output int weCyc, output logic [31:0] rd,
                       output logic [31:0] seenAddr, output bit stallOk);
    ackCyc = -1; enCyc = 0; weCyc = 0; rd = '0; seenAddr = '0; stallOk = 1'b1;
    if (isDm) begin
      dmReq = 1'b1; dmWe = we; dmAddr = addr; dmWdata = wdata;
    end else begin
      ifReq = 1'b1; ifAddr = addr;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memEn) begin
        enCyc++;
        seenAddr = memAddr;
        if (memWe) weCyc++;
      end
      if (isDm ? dmAck : ifAck) begin
        ackCyc = i;
        rd = isDm ? dmRdata : ifRdata;
        if ((isDm ? stallMem : stallIf) !== 1'b0) stallOk = 1'b0;
        break;
      end else if ((isDm ? stallMem : stallIf) !== 1'b1) begin
        stallOk = 1'b0;
      end
    end
    ifReq = 1'b0; dmReq = 1'b0; dmWe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifReq = 1'b1; dmReq = 1'b1; dmWe = 1'b0; ifAddr = '0; dmAddr = '0; dmWdata = '0;
    if2Req = 1'b0; dm2Req = 1'b0; dm2We = 1'b0; if2Addr = '0; dm2Addr = '0; dm2Wdata = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({memEn, memWe, ifAck, dmAck} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {memEn, memWe, ifAck, dmAck});
    end
    checks++;
    if ({stallIf, stallMem} !== 2'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 00", {stallIf, stallMem});
    end
    checks++;
    if (ifRdata !== 32'h0 || dmRdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", ifRdata, dmRdata);
    end
    checks++;
    if ({mem2En, if2Ack, dm2Ack} !== 3'b0) begin
      errors++; $display("FAIL reset_lat1: got %b want 000", {mem2En, if2Ack, dm2Ack});
    end
    ifReq = 1'b0; dmReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    int a, e, w; logic [31:0] rd, sa; bit sok;
    doAcc(1'b0, 1'b0, 32'h10, 32'h0, a, e, w, rd, sa, sok);
    checks++;
    if (a !== 3) begin errors++; $display("FAIL fetch_ack_cycle: got %0d want 3", a); end
    checks++;
    if (e !== 2) begin errors++; $display("FAIL fetch_en_cycles: got %0d want 2", e); end
    checks++;
    if (rd !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata: got %h want 00500093", rd); end
    checks++;
    if (sa !== 32'h10 || w !== 0) begin
      errors++; $display("FAIL fetch_addr_we: got %h/%0d want 10/0", sa, w);
    end
    checks++;
    if (sok !== 1'b1) begin errors++; $display("FAIL fetch_stall: got bad want stall until ack"); end
  endtask

  task automatic test_store_load();
    int a, e, w; logic [31:0] rd, sa; bit sok;
    doAcc(1'b1, 1'b0, 32'h10, 32'h0, a, e, w, rd, sa, sok);
    checks++;
    if (rd !== 32'h0050_0093 || a !== 3) begin
      errors++; $display("FAIL load1: got %h @%0d want 00500093 @3", rd, a);
    end
    doAcc(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, a, e, w, rd, sa, sok);
    checks++;
    if (w !== 2 || a !== 3) begin errors++; $display("FAIL store_we: got we=%0d ack@%0d want 2/3", w, a); end
    checks++;
    if (rd !== 32'h0050_0093) begin errors++; $display("FAIL store_rdata_hold: got %h want 00500093", rd); end
    checks++;
    if (sok !== 1'b1) begin errors++; $display("FAIL store_stall: got bad want stall until ack"); end
    doAcc(1'b1, 1'b0, 32'h40, 32'h0, a, e, w, rd, sa, sok);
    checks++;
    if (rd !== 32'hDEAD_BEEF || w !== 0) begin
      errors++; $display("FAIL load2: got %h we=%0d want deadbeef we=0", rd, w);
    end
    checks++;
    if (ifRdata !== 32'h0050_0093) begin errors++; $display("FAIL if_rdata_hold: got %h want 00500093", ifRdata); end
  endtask

  task automatic test_streak();
    logic expOrder [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic got [7];
    int   ackT [7];
    int   n = 0;
    bit   spacingOk = 1'b1;
    bit   stallOk = 1'b1;
    ifReq = 1'b1; ifAddr = 32'h10; dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h40;
    for (int k = 0; k < 7; k++) begin got[k] = 1'bx; ackT[k] = 0; end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (dmAck || ifAck) begin
        got[n] = dmAck;
        ackT[n] = c;
        if (ifAck && stallMem !== 1'b1) stallOk = 1'b0;
        n++;
        if (n == 7) break;
      end
    end
    ifReq = 1'b0; dmReq = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== expOrder[k]) begin
        errors++; $display("FAIL streak_grant%0d: got dm=%b want dm=%b", k, got[k], expOrder[k]);
      end
    end
    for (int k = 1; k < 7; k++) if (ackT[k] - ackT[k-1] != 4) spacingOk = 1'b0;
    checks++;
    if (spacingOk !== 1'b1) begin errors++; $display("FAIL streak_spacing: got %0d,%0d want 4 apart", ackT[0], ackT[1]); end
    checks++;
    if (stallOk !== 1'b1) begin errors++; $display("FAIL streak_stall_mem: got 0 want 1 at if_ack"); end
  endtask

  task automatic test_drop();
    int acks = 0, ens = 0, ackAt = -1;
    ifReq = 1'b1; ifAddr = 32'h10;
    @(negedge clk);
    checks++;
    if (memEn !== 1'b1) begin errors++; $display("FAIL drop_access: got %b want 1", memEn); end
    ifReq = 1'b0;
    #1;
    checks++;
    if (stallIf !== 1'b0) begin errors++; $display("FAIL drop_stall: got %b want 0", stallIf); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memEn) ens++;
      if (ifAck || dmAck) begin acks++; ackAt = c; end
    end
    checks++;
    if (acks !== 1 || ackAt !== 2) begin
      errors++; $display("FAIL drop_ack: got %0d acks @%0d want 1 @2", acks, ackAt);
    end
    checks++;
    if (ens !== 1) begin errors++; $display("FAIL drop_en: got %0d want 1", ens); end
  endtask

  task automatic test_reset_mid();
    int a, e, w; logic [31:0] rd, sa; bit sok;
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h40;
    @(negedge clk);
    checks++;
    if (memEn !== 1'b1) begin errors++; $display("FAIL rstmid_access: got %b want 1", memEn); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({memEn, dmAck, ifAck, stallMem, stallIf} !== 5'b0) begin
      errors++; $display("FAIL rstmid_async: got %b want 00000", {memEn, dmAck, ifAck, stallMem, stallIf});
    end
    checks++;
    if (ifRdata !== 32'h0 || dmRdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", ifRdata, dmRdata);
    end
    @(negedge clk);
    rst = 1'b1;
    doAcc(1'b1, 1'b0, 32'h40, 32'h0, a, e, w, rd, sa, sok);
    checks++;
    if (a !== 3 || e !== 2) begin errors++; $display("FAIL rstmid_fresh: got ack@%0d en=%0d want 3/2", a, e); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_rdata2: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h100, 32'h204, 32'h308};
    logic [31:0] seen [3];
    logic [31:0] rd [3];
    int ackT [3];
    int expT [3] = '{2, 5, 8};
    int n = 0, enCnt = 0;
    for (int k = 0; k < 3; k++) begin seen[k] = '0; rd[k] = '0; ackT[k] = -1; end
    if2Req = 1'b1; if2Addr = addrs[0];
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem2En) begin enCnt++; seen[n] = mem2Addr; end
      if (if2Ack) begin
        ackT[n] = c; rd[n] = if2Rdata; n++;
        if (n == 3) break;
        if2Addr = addrs[n];
      end
    end
    if2Req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ackT[k] !== expT[k]) begin errors++; $display("FAIL lat1_ack%0d: got %0d want %0d", k, ackT[k], expT[k]); end
      checks++;
      if (seen[k] !== addrs[k]) begin errors++; $display("FAIL lat1_addr%0d: got %h want %h", k, seen[k], addrs[k]); end
      checks++;
      if (rd[k] !== (addrs[k] ^ 32'hA5A5_0000)) begin
        errors++; $display("FAIL lat1_rdata%0d: got %h want %h", k, rd[k], addrs[k] ^ 32'hA5A5_0000);
      end
    end
    checks++;
    if (enCnt !== 3) begin errors++; $display("FAIL lat1_en: got %0d want 3", enCnt); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_streak();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
